// File: rtl/ascon_state_io_pkg.sv
// Shared types and constants for the Ascon state load/permute/unload engine.
// Holds the 320-bit state type, the round index type and the round-constant helper.
package ascon_state_io_pkg;

    typedef logic [63:0]      word_t;
    typedef logic [4:0][63:0] ascon_state;
    typedef logic [3:0]       round;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StPermute,
        StUnload
    } state_io_fsm_t;

    localparam round RND_P12_FIRST = 4'h4;
    localparam round RND_P8_FIRST  = 4'h8;
    localparam round RND_LAST      = 4'hF;

    // Round index r runs 4..15; the constant is built from the p12 position r-4.
    function automatic logic [7:0] pc(round r);
        round i;
        i = r - RND_P12_FIRST;
        return {4'hF - i, i};
    endfunction

endpackage

// File: rtl/ascon_state_io_if.sv
// Word-stream bundle between a bus master and the Ascon state engine.
// Carries the input stream, the output stream and the busy flag.
interface ascon_state_io_if;
    import ascon_state_io_pkg::*;

    logic  in_valid;
    logic  in_ready;
    word_t in_data;
    logic  mode;
    logic  out_valid;
    logic  out_ready;
    word_t out_data;
    logic  out_last;
    logic  busy;

    modport master (
        output in_valid, in_data, mode, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, mode, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );

endinterface

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, 5-bit S-box layer, linear diffusion.
// The round index selects the constant mixed into word x2.
module ascon_round
    import ascon_state_io_pkg::*;
(
    input  ascon_state din,
    input  round       rnd,
    output ascon_state dout
);

    function automatic word_t ror64(word_t x, int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    word_t a0, a1, a2, a3, a4;
    word_t t0, t1, t2, t3, t4;
    word_t b0, b1, b2, b3, b4;
    word_t s0, s1, s2, s3, s4;

    always_comb begin
        // Constant addition followed by the input mixing of the S-box.
        a0 = din[0] ^ din[4];
        a1 = din[1];
        a2 = din[2] ^ {56'h0, pc(rnd)} ^ din[1];
        a3 = din[3];
        a4 = din[4] ^ din[3];

        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;

        b0 = a0 ^ t1;
        b1 = a1 ^ t2;
        b2 = a2 ^ t3;
        b3 = a3 ^ t4;
        b4 = a4 ^ t0;

        s1 = b1 ^ b0;
        s0 = b0 ^ b4;
        s3 = b3 ^ b2;
        s2 = ~b2;
        s4 = b4;

        dout[0] = s0 ^ ror64(s0, 19) ^ ror64(s0, 28);
        dout[1] = s1 ^ ror64(s1, 61) ^ ror64(s1, 39);
        dout[2] = s2 ^ ror64(s2, 1)  ^ ror64(s2, 6);
        dout[3] = s3 ^ ror64(s3, 10) ^ ror64(s3, 17);
        dout[4] = s4 ^ ror64(s4, 7)  ^ ror64(s4, 41);
    end

endmodule

// File: rtl/ascon_state_io.sv
// Loads a 320-bit Ascon state as five 64-bit words, runs p12/p8 one round per cycle,
// then streams the result back out. Optional build macro: ASCON_STATE_IO_ZEROIZE_EN.
module ascon_state_io
    import ascon_state_io_pkg::*;
(
    input logic             clk,
    input logic             rst,
    ascon_state_io_if.slave bus
);

    state_io_fsm_t fsm_q, fsm_d;
    ascon_state    state_q, state_d;
    logic [2:0]    idx_q, idx_d;
    round          rnd_q, rnd_d;
    logic          mode_q, mode_d;

    ascon_state    round_out;
    logic          in_rdy;
    logic          out_vld;

    ascon_round u_round (
        .din  (state_q),
        .rnd  (rnd_q),
        .dout (round_out)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_q   <= StIdle;
            state_q <= '0;
            idx_q   <= '0;
            rnd_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            rnd_q   <= rnd_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        idx_d   = idx_q;
        rnd_d   = rnd_q;
        mode_d  = mode_q;
        in_rdy  = 1'b0;
        out_vld = 1'b0;

        unique case (fsm_q)
            StIdle: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    state_d[0] = bus.in_data;
                    mode_d     = bus.mode;
                    idx_d      = 3'd1;
                    fsm_d      = StLoad;
                end
            end
            StLoad: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    state_d[idx_q] = bus.in_data;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd4) begin
                        idx_d = 3'd0;
                        rnd_d = mode_q ? RND_P8_FIRST : RND_P12_FIRST;
                        fsm_d = StPermute;
                    end
                end
            end
            StPermute: begin
                state_d = round_out;
                if (rnd_q == RND_LAST) begin
                    idx_d = 3'd0;
                    fsm_d = StUnload;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            StUnload: begin
                out_vld = 1'b1;
                if (bus.out_ready) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd4) begin
                        idx_d = 3'd0;
                        fsm_d = StIdle;
`ifdef ASCON_STATE_IO_ZEROIZE_EN
                        state_d = '0;
`endif
                    end
                end
            end
            default: fsm_d = StIdle;
        endcase
    end

    // in_ready is gated by the reset pin so it reads 0 while reset is held.
    assign bus.in_ready  = in_rdy & rst;
    assign bus.out_valid = out_vld;
    assign bus.out_data  = out_vld ? state_q[idx_q] : '0;
    assign bus.out_last  = out_vld && (idx_q == 3'd4);
    assign bus.busy      = (fsm_q == StPermute) || (fsm_q == StUnload);

endmodule

// File: tb/tb_ascon_state_io.sv
// Directed bench for ascon_state_io: latency, p12/p8 results, stalls, ignored input, reset.
// Expected states come from a table-driven Ascon permutation model in the bench.
module tb_ascon_state_io;
    import ascon_state_io_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ascon_state_io_if bus ();

    ascon_state_io dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam int ROT1 [5] = '{19, 61, 1, 10, 7};
    localparam int ROT2 [5] = '{28, 39, 6, 17, 41};

    function automatic ascon_state model_perm(input ascon_state s, input int nr);
        logic [63:0] x [5];
        logic [63:0] y;
        logic [4:0]  col;
        logic [4:0]  o;
        int          c;
        for (int k = 0; k < 5; k++) x[k] = s[k];
        for (int r = 12 - nr; r < 12; r++) begin
            c = ((15 - r) << 4) | r;
            x[2][7:0] = x[2][7:0] ^ 8'(c);
            for (int j = 0; j < 64; j++) begin
                col = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
                o = SBOX[col];
                x[0][j] = o[4];
                x[1][j] = o[3];
                x[2][j] = o[2];
                x[3][j] = o[1];
                x[4][j] = o[0];
            end
            for (int k = 0; k < 5; k++) begin
                y = x[k];
                for (int j = 0; j < 64; j++)
                    x[k][j] = y[j] ^ y[(j + ROT1[k]) % 64] ^ y[(j + ROT2[k]) % 64];
            end
        end
        for (int k = 0; k < 5; k++) model_perm[k] = x[k];
    endfunction

    function automatic ascon_state mk(input word_t w0, input word_t w1, input word_t w2,
                                      input word_t w3, input word_t w4);
        mk = {w4, w3, w2, w1, w0};
    endfunction

    // Drives s0..s4 back to back; mode is inverted after s0 to show it is ignored.
    task automatic load_job(input ascon_state s, input logic m, input logic hold_valid);
        for (int w = 0; w < 5; w++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = s[w];
            bus.mode     = (w == 0) ? m : ~m;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL load_ready w%0d: in_ready=%b expected 1", w, bus.in_ready);
            end
        end
        @(posedge clk);
        #1;
        if (hold_valid) bus.in_data = 64'hdead_beef_0bad_f00d;
        else bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int exp_lat, input string name);
        int cnt;
        cnt = 0;
        while (cnt < 40) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
            if (bus.out_valid === 1'b1) break;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_permute: in_ready=%b busy=%b expected 0/1", name,
                         bus.in_ready, bus.busy);
            end
        end
        checks++;
        if (cnt != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: out_valid after %0d cycles expected %0d", name, cnt,
                     exp_lat);
        end
    endtask

    task automatic unload(input ascon_state exp, input logic stall, input string name);
        int         w;
        int         guard;
        logic       tog;
        ascon_state exp_z;
        w = 0;
        guard = 0;
        tog = 1'b0;
        while (w < 5 && guard < 40) begin
            if (guard > 0) @(negedge clk);
            guard++;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp[w] ||
                bus.out_last !== (w == 4)) begin
                errors++;
                $display("FAIL %s_word%0d: valid=%b data=%h last=%b expected 1 %h %b", name, w,
                         bus.out_valid, bus.out_data, bus.out_last, exp[w], (w == 4));
            end
            if (stall) begin
                bus.out_ready = tog;
                tog = ~tog;
            end else begin
                bus.out_ready = 1'b1;
            end
            if (bus.out_ready) w++;
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: out_valid=%b in_ready=%b busy=%b expected 0/1/0", name,
                     bus.out_valid, bus.in_ready, bus.busy);
        end
`ifdef ASCON_STATE_IO_ZEROIZE_EN
        exp_z = '0;
`else
        exp_z = exp;
`endif
        checks++;
        if (dut.state_q !== exp_z) begin
            errors++;
            $display("FAIL %s_state_idle: state=%h expected %h", name, dut.state_q, exp_z);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
            bus.busy !== 1'b0 || bus.out_data !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b last=%b busy=%b data=%h expected all 0",
                     bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.out_data);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_p12();
        ascon_state s;
        s = mk(64'h0, 64'h1, 64'h2, 64'h3, 64'h4);
        load_job(s, 1'b0, 1'b0);
        wait_out(12, "p12");
        unload(model_perm(s, 12), 1'b0, "p12");
    endtask

    task automatic test_p8();
        ascon_state s;
        s = mk(64'h9043340012005440, 64'h4925669902022042, 64'h5532006940392211,
               64'h0011134445600600, 64'h1112223333444555);
        load_job(s, 1'b1, 1'b0);
        wait_out(8, "p8");
        unload(model_perm(s, 8), 1'b0, "p8");
    endtask

    task automatic test_stall();
        ascon_state s;
        s = mk(64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f0f0f0f0f0f0f0f,
               64'hf0f0f0f0f0f0f0f0, 64'h8000000000000001);
        load_job(s, 1'b0, 1'b0);
        wait_out(12, "stall");
        unload(model_perm(s, 12), 1'b1, "stall");
    endtask

    task automatic test_ignore_input();
        ascon_state s;
        s = mk(64'h1111111111111111, 64'h2222222222222222, 64'h3333333333333333,
               64'h4444444444444444, 64'h5555555555555555);
        load_job(s, 1'b1, 1'b1);
        wait_out(8, "ignore");
        bus.in_valid = 1'b0;
        unload(model_perm(s, 8), 1'b0, "ignore");
    endtask

    task automatic test_reset_mid();
        ascon_state s;
        s = mk(64'haaaaaaaaaaaaaaaa, 64'h5555555555555555, 64'h1234, 64'h5678, 64'h9abc);
        load_job(s, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
            bus.busy !== 1'b0 || bus.out_data !== 64'h0) begin
            errors++;
            $display("FAIL midreset_outputs: rdy=%b vld=%b last=%b busy=%b data=%h exp all 0",
                     bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.out_data);
        end
        checks++;
        if (dut.state_q !== '0 || dut.rnd_q !== 4'h0 || dut.idx_q !== 3'd0) begin
            errors++;
            $display("FAIL midreset_regs: state=%h rnd=%h idx=%0d expected 0", dut.state_q,
                     dut.rnd_q, dut.idx_q);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release: rdy=%b busy=%b vld=%b expected 1/0/0",
                     bus.in_ready, bus.busy, bus.out_valid);
        end
        s = '0;
        load_job(s, 1'b0, 1'b0);
        wait_out(12, "zero");
        unload(model_perm(s, 12), 1'b0, "zero");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.mode = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_p12();
        test_p8();
        test_stall();
        test_ignore_input();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
